// File: rtl/riscv_mem_pkg.sv
// Shared load/store unit types: funct3 access encodings, LSU state enum and
// the alignment legality check used by the MEM stage.
package riscv_mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } lsu_state_t;

  // Doubleword and unsigned-word accesses only exist on a 64-bit datapath.
  function automatic logic misaligned(input logic [2:0] funct3,
                                      input logic [2:0] off,
                                      input logic       is64);
    logic bad;
    case (funct3)
      F3_B, F3_BU: bad = 1'b0;
      F3_H, F3_HU: bad = off[0];
      F3_W:        bad = |off[1:0];
      F3_WU:       bad = !is64 || (|off[1:0]);
      F3_D:        bad = !is64 || (|off);
      default:     bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane steering: store enables/replication, load
// extraction with sign/zero extension, and misalign detection.
module lsu_align
  import riscv_mem_pkg::*;
#(
  parameter  int XLEN   = 32,
  localparam int NBYTES = XLEN / 8,
  localparam int OFFW   = $clog2(XLEN / 8)
) (
  input  logic [2:0]        st_funct3,
  input  logic [2:0]        st_addr_lo,
  input  logic [XLEN-1:0]   st_data,
  input  logic [2:0]        ld_funct3,
  input  logic [OFFW-1:0]   ld_off,
  input  logic [XLEN-1:0]   ld_rdata,
  output logic [NBYTES-1:0] be,
  output logic [XLEN-1:0]   wdata,
  output logic [XLEN-1:0]   ld_data,
  output logic              misalign
);

  logic [OFFW-1:0] st_off;
  logic [7:0]      size_mask;
  logic [15:0]     be_wide;
  logic [XLEN-1:0] sh;

  assign st_off   = st_addr_lo[OFFW-1:0];
  assign misalign = misaligned(st_funct3, st_addr_lo, XLEN == 64);
  assign be       = be_wide[NBYTES-1:0];

  always_comb begin
    case (st_funct3[1:0])
      2'd0:    size_mask = 8'h01;
      2'd1:    size_mask = 8'h03;
      2'd2:    size_mask = 8'h0F;
      default: size_mask = 8'hFF;
    endcase
    be_wide = {8'h00, size_mask} << st_off;

    // Replicate so the addressed lanes carry the data whatever the offset.
    case (st_funct3[1:0])
      2'd0:    wdata = {NBYTES{st_data[7:0]}};
      2'd1:    wdata = {(NBYTES / 2){st_data[15:0]}};
      2'd2:    wdata = {(XLEN / 32){st_data[31:0]}};
      default: wdata = st_data;
    endcase
  end

  always_comb begin
    sh = ld_rdata >> {ld_off, 3'b000};
    case (ld_funct3)
      F3_B:    ld_data = XLEN'($signed(sh[7:0]));
      F3_H:    ld_data = XLEN'($signed(sh[15:0]));
      F3_W:    ld_data = XLEN'($signed(sh[31:0]));
      F3_BU:   ld_data = XLEN'(sh[7:0]);
      F3_HU:   ld_data = XLEN'(sh[15:0]);
      F3_WU:   ld_data = XLEN'(sh[31:0]);
      default: ld_data = sh;
    endcase
  end

endmodule

// File: rtl/memory_stage_lsu.sv
// MEM stage with MEM/WB register driving a req/gnt/rvalid data-memory port;
// stalls upstream while a request or read response is outstanding.
module memory_stage_lsu
  import riscv_mem_pkg::*;
#(
  parameter  int XLEN       = 32,
  parameter  int REG_ADDR_W = 5,
  localparam int NBYTES     = XLEN / 8,
  localparam int OFFW       = $clog2(XLEN / 8)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  RegWriteM,
  input  logic                  MemtoRegM,
  input  logic                  JumpM,
  input  logic                  MemReadM,
  input  logic                  MemWriteM,
  input  logic [2:0]            Funct3M,
  input  logic [REG_ADDR_W-1:0] WriteReg_M,
  input  logic [XLEN-1:0]       PCPlus4M,
  input  logic [XLEN-1:0]       ALU_ResultM,
  input  logic [XLEN-1:0]       WriteDataM,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [NBYTES-1:0]     dmem_be,
  output logic [XLEN-1:0]       dmem_addr,
  output logic [XLEN-1:0]       dmem_wdata,
  input  logic                  dmem_gnt,
  input  logic                  dmem_rvalid,
  input  logic [XLEN-1:0]       dmem_rdata,
  output logic                  StallM,
  output logic                  RegWriteW,
  output logic                  MemtoRegW,
  output logic                  JumpW,
  output logic                  MisalignW,
  output logic [REG_ADDR_W-1:0] WriteReg_W,
  output logic [XLEN-1:0]       PCPlus4W,
  output logic [XLEN-1:0]       ALU_ResultW,
  output logic [XLEN-1:0]       ReadDataW
);

  lsu_state_t state, state_nx;

  logic              mem_op, misalign, legal, trap;
  logic [NBYTES-1:0] be_cur, req_be;
  logic [XLEN-1:0]   wdata_cur, req_wdata;
  logic [XLEN-1:0]   addr_cur, req_addr;
  logic [XLEN-1:0]   ld_data;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [OFFW-1:0]   req_off;

  assign mem_op   = MemReadM | MemWriteM;
  assign trap     = mem_op & misalign;
  assign legal    = mem_op & ~misalign;
  assign addr_cur = {ALU_ResultM[XLEN-1:OFFW], {OFFW{1'b0}}};

  lsu_align #(.XLEN(XLEN)) u_align (
    .st_funct3  (Funct3M),
    .st_addr_lo (ALU_ResultM[2:0]),
    .st_data    (WriteDataM),
    .ld_funct3  (req_funct3),
    .ld_off     (req_off),
    .ld_rdata   (dmem_rdata),
    .be         (be_cur),
    .wdata      (wdata_cur),
    .ld_data    (ld_data),
    .misalign   (misalign)
  );

  // Request fields are latched at issue and drive the port through REQ/RESP.
  always_ff @(posedge clk) begin
    if (state == IDLE && legal) begin
      req_addr   <= addr_cur;
      req_be     <= be_cur;
      req_wdata  <= wdata_cur;
      req_we     <= MemWriteM;
      req_funct3 <= Funct3M;
      req_off    <= ALU_ResultM[OFFW-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    dmem_req   = 1'b0;
    StallM     = 1'b0;
    dmem_we    = MemWriteM;
    dmem_be    = be_cur;
    dmem_addr  = addr_cur;
    dmem_wdata = wdata_cur;
    case (state)
      IDLE: begin
        if (legal) begin
          dmem_req = 1'b1;
          if (!dmem_gnt) begin
            state_nx = REQ;
            StallM   = 1'b1;
          end else if (!MemWriteM) begin
            state_nx = RESP;
            StallM   = 1'b1;
          end
        end
      end
      REQ: begin
        dmem_req   = 1'b1;
        dmem_we    = req_we;
        dmem_be    = req_be;
        dmem_addr  = req_addr;
        dmem_wdata = req_wdata;
        StallM     = 1'b1;
        if (dmem_gnt) begin
          // A store granted here completes now so the held op is not reissued.
          if (req_we) begin
            state_nx = IDLE;
            StallM   = 1'b0;
          end else begin
            state_nx = RESP;
          end
        end
      end
      RESP: begin
        dmem_we    = req_we;
        dmem_be    = req_be;
        dmem_addr  = req_addr;
        dmem_wdata = req_wdata;
        StallM     = 1'b1;
        if (dmem_rvalid) begin
          state_nx = IDLE;
          StallM   = 1'b0;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // MEM/WB boundary: bubble while stalled so each op writes back exactly once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      RegWriteW   <= 1'b0;
      MemtoRegW   <= 1'b0;
      JumpW       <= 1'b0;
      MisalignW   <= 1'b0;
      WriteReg_W  <= '0;
      PCPlus4W    <= '0;
      ALU_ResultW <= '0;
      ReadDataW   <= '0;
    end else if (StallM) begin
      RegWriteW   <= 1'b0;
      MemtoRegW   <= 1'b0;
      JumpW       <= 1'b0;
      MisalignW   <= 1'b0;
    end else begin
      RegWriteW   <= RegWriteM & ~trap;
      MemtoRegW   <= MemtoRegM;
      JumpW       <= JumpM;
      MisalignW   <= trap;
      WriteReg_W  <= WriteReg_M;
      PCPlus4W    <= PCPlus4M;
      ALU_ResultW <= ALU_ResultM;
      ReadDataW   <= (state == RESP) ? ld_data : '0;
    end
  end

endmodule
